// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: slew-limited servo pulse-width sequencer with PWM frame strobe.
// Optional feature: define SERVO_AUTO_SWEEP_EN to let IDLE self-issue MIN/MAX sweep targets.
module servo_ramp_ctrl #(
    parameter int unsigned FRAME_CLKS  = 480000,
    parameter int unsigned MIN_US      = 1000,
    parameter int unsigned MAX_US      = 2000,
    parameter int unsigned CENTER_US   = 1500,
    parameter int unsigned STEP_US     = 10,
    parameter int unsigned HOLD_FRAMES = 5
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_target,
    output logic        cmd_ready,
    output logic        frame_tick,
    output logic [15:0] pos_us,
    output logic        busy,
    output logic        done
);
    localparam int CW = $clog2(FRAME_CLKS);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [15:0] MIN_W  = 16'(MIN_US);
    localparam logic [15:0] MAX_W  = 16'(MAX_US);
    localparam logic [15:0] STEP_W = 16'(STEP_US);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q;
    logic [15:0]     pos_q, tgt_q;
    logic            ready_q, busy_q, done_q;
    logic [15:0]     clamped, diff;
    logic            up, close;
`ifdef SERVO_AUTO_SWEEP_EN
    logic            sweep_hi_q;
`endif

    assign frame_tick = (cnt_q == CW'(FRAME_CLKS - 1));
    assign cnt_d      = frame_tick ? '0 : cnt_q + 1'b1;
    assign clamped    = (cmd_target < MIN_W) ? MIN_W : (cmd_target > MAX_W) ? MAX_W : cmd_target;
    assign up         = tgt_q > pos_q;
    assign diff       = up ? tgt_q - pos_q : pos_q - tgt_q;
    assign close      = diff <= STEP_W;
    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pos_us     = pos_q;

    // Free-running frame counter; the strobe marks its last count.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // Sequencer: accept target in IDLE, step once per frame in RAMP, settle in HOLD.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            pos_q   <= 16'(CENTER_US);
            tgt_q   <= 16'(CENTER_US);
            hold_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERVO_AUTO_SWEEP_EN
            sweep_hi_q <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        tgt_q   <= clamped;
                        state_q <= RAMP;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
`ifdef SERVO_AUTO_SWEEP_EN
                    else if (frame_tick) begin
                        tgt_q      <= sweep_hi_q ? MAX_W : MIN_W;
                        sweep_hi_q <= !sweep_hi_q;
                        state_q    <= RAMP;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
`endif
                end
                RAMP: begin
                    if (frame_tick) begin
                        if (close) begin
                            pos_q   <= tgt_q;
                            hold_q  <= '0;
                            state_q <= HOLD;
                        end else begin
                            pos_q <= up ? pos_q + STEP_W : pos_q - STEP_W;
                        end
                    end
                end
                HOLD: begin
                    if (frame_tick) begin
                        if (hold_q == HW'(HOLD_FRAMES - 1)) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
